// File: rtl/morse_pkg.sv
// morse_pkg: shared types, letter codes, timing constants and the pattern
// decoder for the Morse receiver.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MARK     = 2'd1,
        SPACE    = 2'd2,
        WAIT_GAP = 2'd3
    } state_t;

    localparam logic [2:0] LETTER_S = 3'd0;
    localparam logic [2:0] LETTER_T = 3'd1;
    localparam logic [2:0] LETTER_U = 3'd2;
    localparam logic [2:0] LETTER_V = 3'd3;
    localparam logic [2:0] LETTER_W = 3'd4;
    localparam logic [2:0] LETTER_X = 3'd5;
    localparam logic [2:0] LETTER_Y = 3'd6;
    localparam logic [2:0] LETTER_Z = 3'd7;

    localparam logic [2:0] MAX_ELEMS  = 3'd4;
    localparam logic [2:0] DOT_UNITS  = 3'd1;
    localparam logic [2:0] DASH_UNITS = 3'd3;
    localparam logic [2:0] GAP_UNITS  = 3'd3;
    localparam logic [2:0] RUN_SAT    = 3'd4;

    // Patterns are {element count, elements}; elements are right-aligned,
    // first element in the highest used bit, 1 = dash, unused bits zero.
    localparam logic [6:0] PAT_S = {3'd3, 4'b0000};
    localparam logic [6:0] PAT_T = {3'd1, 4'b0001};
    localparam logic [6:0] PAT_U = {3'd3, 4'b0001};
    localparam logic [6:0] PAT_V = {3'd4, 4'b0001};
    localparam logic [6:0] PAT_W = {3'd3, 4'b0011};
    localparam logic [6:0] PAT_X = {3'd4, 4'b1001};
    localparam logic [6:0] PAT_Y = {3'd4, 4'b1011};
    localparam logic [6:0] PAT_Z = {3'd4, 4'b1100};

    typedef struct packed {
        logic       ok;
        logic [2:0] letter;
    } decode_t;

    function automatic decode_t decode_pattern(input logic [2:0] count,
                                               input logic [3:0] elems);
        decode_t r;
        r.ok     = 1'b1;
        r.letter = LETTER_S;
        case ({count, elems})
            PAT_S:   r.letter = LETTER_S;
            PAT_T:   r.letter = LETTER_T;
            PAT_U:   r.letter = LETTER_U;
            PAT_V:   r.letter = LETTER_V;
            PAT_W:   r.letter = LETTER_W;
            PAT_X:   r.letter = LETTER_X;
            PAT_Y:   r.letter = LETTER_Y;
            PAT_Z:   r.letter = LETTER_Z;
            default: r.ok = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/morse_tick_gen.sv
// morse_tick_gen: one-clock unit tick every TICK_DIV clocks from a
// down-counter that reloads with TICK_DIV-1 after reaching zero.
module morse_tick_gen #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick  = (cnt_q == '0);
    assign cnt_d = tick ? RELOAD : cnt_q - CW'(1);

    // Divider counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_q <= RELOAD;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/morse_decoder.sv
// morse_decoder: samples a Morse on/off line once per unit, classifies marks
// and gaps, and decodes letters S..Z to a 3-bit index with valid/error pulses.
// Build option MORSE_EXT_TICK_EN: sampling is driven by the tick_in port and
// the internal divider (and TICK_DIV) is unused.
//
// state    | meaning
// IDLE     | line quiet, no letter in progress
// MARK     | counting a mark (run = units high so far, saturates at 4)
// SPACE    | counting a gap after a valid element (run = zero units)
// WAIT_GAP | malformed letter, waiting for a 3-unit gap before re-arming
module morse_decoder
    import morse_pkg::*;
#(
    parameter int TICK_DIV = 25000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       serial_in,
`ifdef MORSE_EXT_TICK_EN
    input  logic       tick_in,
`endif
    output logic [2:0] letter,
    output logic       valid,
    output logic       error
);

    logic tick;

`ifdef MORSE_EXT_TICK_EN
    assign tick = tick_in;
`else
    morse_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );
`endif

    logic sync1_q, sync2_q;

    state_t     state_q,  state_d;
    logic [2:0] run_q,    run_d;
    logic [3:0] elems_q,  elems_d;
    logic [2:0] count_q,  count_d;
    logic [2:0] letter_q, letter_d;
    logic       valid_q,  valid_d;
    logic       error_q,  error_d;
    decode_t    dec;

    assign dec = decode_pattern(count_q, elems_q);

    // Two-flop synchronizer for the asynchronous Morse line.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= serial_in;
            sync2_q <= sync1_q;
        end
    end

    // FSM and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            run_q    <= '0;
            elems_q  <= '0;
            count_q  <= '0;
            letter_q <= LETTER_S;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            elems_q  <= elems_d;
            count_q  <= count_d;
            letter_q <= letter_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    // Next-state, run/element bookkeeping and pulse generation on unit ticks.
    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        elems_d  = elems_q;
        count_d  = count_q;
        letter_d = letter_q;
        valid_d  = 1'b0;
        error_d  = 1'b0;

        if (tick) begin
            case (state_q)
                IDLE: begin
                    run_d = '0;
                    if (sync2_q) begin
                        state_d = MARK;
                        run_d   = 3'd1;
                        elems_d = '0;
                        count_d = '0;
                    end
                end
                MARK: begin
                    if (sync2_q) begin
                        if (run_q != RUN_SAT) run_d = run_q + 3'd1;
                    end else if ((run_q == DOT_UNITS || run_q == DASH_UNITS)
                                 && count_q != MAX_ELEMS) begin
                        elems_d = {elems_q[2:0], (run_q == DASH_UNITS)};
                        count_d = count_q + 3'd1;
                        state_d = SPACE;
                        run_d   = 3'd1;
                    end else begin
                        // The terminating zero counts toward the recovery gap.
                        error_d = 1'b1;
                        state_d = WAIT_GAP;
                        run_d   = 3'd1;
                    end
                end
                SPACE: begin
                    if (sync2_q) begin
                        state_d = MARK;
                        run_d   = 3'd1;
                    end else if (run_q == GAP_UNITS - 3'd1) begin
                        state_d = IDLE;
                        run_d   = '0;
                        if (dec.ok) begin
                            valid_d  = 1'b1;
                            letter_d = dec.letter;
                        end else begin
                            error_d = 1'b1;
                        end
                    end else begin
                        run_d = run_q + 3'd1;
                    end
                end
                WAIT_GAP: begin
                    if (sync2_q) begin
                        run_d = '0;
                    end else if (run_q == GAP_UNITS - 3'd1) begin
                        state_d = IDLE;
                        run_d   = '0;
                    end else begin
                        run_d = run_q + 3'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    run_d   = '0;
                end
            endcase
        end
    end

    assign letter = letter_q;
    assign valid  = valid_q;
    assign error  = error_q;

endmodule

// File: tb/tb_morse_decoder.sv
// tb_morse_decoder: drives unit-aligned Morse traffic (directed and random
// letters, unknown patterns, bad mark lengths, overlong letters, mid-letter
// reset) and checks pulses against a string-table reference via a scoreboard.
module tb_morse_decoder;

    localparam int TICK_DIV = 4;
    localparam int HALF     = 5;
    localparam int ERR      = 8;

    logic       clock;
    logic       reset;
    logic       serial_in;
    logic [2:0] letter;
    logic       valid;
    logic       error;

    initial clock = 1'b0;
    always #HALF clock = ~clock;

`ifdef MORSE_EXT_TICK_EN
    logic tick_in;
    int   tdiv;
    always @(posedge clock or posedge reset) begin
        if (reset)          tdiv <= TICK_DIV - 1;
        else if (tdiv == 0) tdiv <= TICK_DIV - 1;
        else                tdiv <= tdiv - 1;
    end
    assign tick_in = (tdiv == 0);
`endif

    morse_decoder #(.TICK_DIV(TICK_DIV)) dut (
        .clock     (clock),
        .reset     (reset),
        .serial_in (serial_in),
`ifdef MORSE_EXT_TICK_EN
        .tick_in   (tick_in),
`endif
        .letter    (letter),
        .valid     (valid),
        .error     (error)
    );

    typedef struct {
        int  code;
        time t;
    } exp_t;

    exp_t  sb[$];
    bit    u_bits[$];
    int    u_exp[$];
    int    vectors = 0;
    int    misc    = 0;
    bit    mon_en  = 0;
    int    model_letter = 0;
    string PATS[8] = '{"...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

    task automatic chk(string name, int act, int expv);
        vectors++;
        if (act !== expv) begin
            misc++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: a letter is whatever table entry matches its dot/dash string.
    function automatic int ref_decode(string s);
        for (int i = 0; i < 8; i++)
            if (s == PATS[i]) return i;
        return ERR;
    endfunction

    function automatic string rand_pat(int n);
        string s = "";
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 1) s = {s, "-"};
            else                           s = {s, "."};
        end
        return s;
    endfunction

    task automatic put(bit b, int e);
        u_bits.push_back(b);
        u_exp.push_back(e);
    endtask

    task automatic put_mark(int n);
        for (int i = 0; i < n; i++) put(1'b1, -1);
    endtask

    task automatic put_zeros(int n, int e1, int e3);
        for (int i = 0; i < n; i++)
            put(1'b0, (i == 0) ? e1 : ((i == 2) ? e3 : -1));
    endtask

    task automatic put_elems(string s);
        for (int i = 0; i < s.len(); i++) begin
            put_mark((s[i] == "-") ? 3 : 1);
            put_zeros($urandom_range(1, 2), -1, -1);
        end
    endtask

    // Whole letter ending in a 3..tmax-unit gap; pulse on the third zero.
    task automatic put_str(string s, int gmin, int gmax, int tmax);
        for (int i = 0; i < s.len(); i++) begin
            put_mark((s[i] == "-") ? 3 : 1);
            if (i < s.len() - 1) put_zeros($urandom_range(gmin, gmax), -1, -1);
            else                 put_zeros($urandom_range(3, tmax), -1, ref_decode(s));
        end
    endtask

    // After an offending mark: error on the first zero, then optional junk
    // marks with short gaps (absorbed silently), then a closing long gap.
    task automatic put_abort_tail();
        if ($urandom_range(0, 1) == 1) begin
            int nj;
            nj = $urandom_range(1, 3);
            put_zeros($urandom_range(1, 2), ERR, -1);
            for (int j = 0; j < nj; j++) begin
                put_mark($urandom_range(1, 6));
                if (j < nj - 1) put_zeros($urandom_range(1, 2), -1, -1);
            end
            put_zeros($urandom_range(3, 5), -1, -1);
        end else begin
            put_zeros($urandom_range(3, 6), ERR, -1);
        end
    endtask

    task automatic run_units();
        bit b;
        int e;
        while (u_bits.size() > 0) begin
            b = u_bits.pop_front();
            e = u_exp.pop_front();
            serial_in = b;
            repeat (TICK_DIV) @(posedge clock);
            if (e >= 0) sb.push_back('{e, $time + HALF});
            @(negedge clock);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("rst_letter", int'(letter), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_pending", sb.size(), 0);
        model_letter = 0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever a pulse appears and tracks letter.
    always @(negedge clock) begin
        exp_t e;
        if (mon_en) begin
            chk("valid_error_exclusive", int'(valid & error), 0);
            if (valid || error) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", int'({valid, error}), 0);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_time", int'($time) - int'(e.t), 0);
                    chk("pulse_kind", error ? ERR : int'(letter), e.code);
                    if (e.code < ERR) model_letter = e.code;
                end
            end else if (sb.size() > 0 && $time >= sb[0].t) begin
                e = sb.pop_front();
                chk("missed_pulse", int'({valid, error}), (e.code == ERR) ? 1 : 2);
            end
            chk("letter_hold", int'(letter), model_letter);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        reset     = 1'b1;
        serial_in = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("reset_letter", int'(letter), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_error", int'(error), 0);
        mon_en = 1'b1;

        // Quiet line.
        put_zeros(20, -1, -1);
        run_units();

        // S, then X followed by T, with exact single-unit gaps.
        put_str("...", 1, 1, 3);
        put_str("-..-", 1, 1, 3);
        put_str("-", 1, 1, 3);
        run_units();

        // Two-unit mark, then U.
        put_mark(2);
        put_zeros(3, ERR, -1);
        put_str("..-", 1, 1, 3);
        run_units();

        // Five dots: error on the fifth, rest absorbed.
        put_elems("....");
        put_mark(1);
        put_zeros(4, ERR, -1);
        run_units();

        // Mark longer than 4 units saturates and errors at its end.
        put_mark(7);
        put_zeros(3, ERR, -1);
        run_units();

        // Unknown two-element pattern.
        put_str(".-", 1, 2, 4);
        run_units();

        // Reset in the middle of W's second dash, then Z.
        put_mark(1);
        put_zeros(1, -1, -1);
        put_mark(3);
        put_zeros(1, -1, -1);
        put_mark(2);
        run_units();
        do_reset();
        put_str("--..", 1, 2, 4);
        run_units();

        // Random traffic.
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            if (kind < 5) begin
                put_str(PATS[$urandom_range(0, 7)], 1, 2, 6);
            end else if (kind < 7) begin
                put_str(rand_pat($urandom_range(1, 4)), 1, 2, 6);
            end else if (kind < 9) begin
                int bad;
                put_elems(rand_pat($urandom_range(0, 3)));
                bad = $urandom_range(0, 4);
                put_mark((bad == 0) ? 2 : bad + 3);
                put_abort_tail();
            end else begin
                put_elems(rand_pat(4));
                put_mark(($urandom_range(0, 1) == 1) ? 3 : 1);
                put_abort_tail();
            end
        end
        run_units();

        put_zeros(8, -1, -1);
        run_units();
        chk("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule
